ped_request: RTL

Pedestrian push-button front end for the traffic light controller. It synchronises and debounces a raw active-low button and latches a crossing request. The request is presented to the light sequencer over a req/ack handshake. While the request is pending, a blinking active-low "WAIT" indicator is driven. After each walk phase it enforces a lockout so a repeated press cannot immediately re-request.

---
 rtl/traffic_pkg.sv | 19 +
 rtl/btn_debounce.sv | 55 +++++
 rtl/ped_request.sv | 91 +++++++++
 3 files changed

// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic light controller: pedestrian FSM states,
// default timing at 27 MHz and the active-low indicator levels.
package traffic_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    SERVING = 2'd2,
    LOCKOUT = 2'd3
  } ped_state_t;

  localparam int unsigned DEF_DEBOUNCE_CYCLES = 540000;
  localparam int unsigned DEF_BLINK_HALF      = 13500000;
  localparam int unsigned DEF_COOLDOWN_CYCLES = 135000000;

  localparam logic LED_ON  = 1'b0;
  localparam logic LED_OFF = 1'b1;

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser, stability-count debouncer and press pulse
// (one cycle, on the debounced 1->0 transition only).
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 540000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n,
  output logic debounced,
  output logic press
);

  localparam logic [31:0] COUNT_LAST = 32'(DEBOUNCE_CYCLES - 1);

  logic        sync1;
  logic        btn_s;
  logic        debounced_d;
  logic [31:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      btn_s <= 1'b1;
    end else begin
      sync1 <= btn_n;
      btn_s <= sync1;
    end
  end

  // The level only flips after btn_s has disagreed for DEBOUNCE_CYCLES edges in a row.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      debounced <= 1'b1;
      count     <= '0;
    end else if (btn_s == debounced) begin
      count <= '0;
    end else if (count == COUNT_LAST) begin
      debounced <= btn_s;
      count     <= '0;
    end else begin
      count <= count + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      debounced_d <= 1'b1;
      press       <= 1'b0;
    end else begin
      debounced_d <= debounced;
      press       <= debounced_d & ~debounced;
    end
  end

endmodule

// File: rtl/ped_request.sv
// Pedestrian push-button front end: latches a crossing request, holds req until
// the sequencer acks, blinks WAIT while pending and locks out after each walk.
module ped_request
  import traffic_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned BLINK_HALF      = DEF_BLINK_HALF,
  parameter int unsigned COOLDOWN_CYCLES = DEF_COOLDOWN_CYCLES
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic btn_n,
  input  logic ack,
  input  logic walk_active,
  output logic req,
  output logic wait_led_n
);

  localparam logic [31:0] BLINK_LAST = 32'(BLINK_HALF - 1);
  localparam logic [31:0] COOL_LAST  = 32'(COOLDOWN_CYCLES - 1);

  ped_state_t  state;
  logic        press;
  logic        debounced_unused;
  logic        walk_d;
  logic        phase_lit;
  logic [31:0] blink_cnt;
  logic [31:0] cool_cnt;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk       (sys_clk),
    .rst_n     (sys_rst_n),
    .btn_n     (btn_n),
    .debounced (debounced_unused),
    .press     (press)
  );

  // wait_led_n is updated alongside state so it is always a clean flop output.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state      <= IDLE;
      walk_d     <= 1'b0;
      phase_lit  <= 1'b0;
      blink_cnt  <= '0;
      cool_cnt   <= '0;
      wait_led_n <= LED_OFF;
    end else begin
      walk_d <= walk_active;
      case (state)
        IDLE: begin
          if (press) begin
            state      <= PENDING;
            blink_cnt  <= '0;
            phase_lit  <= 1'b1;
            wait_led_n <= LED_ON;
          end
        end
        PENDING: begin
          if (ack) begin
            state      <= SERVING;
            wait_led_n <= LED_OFF;
          end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt  <= '0;
            phase_lit  <= ~phase_lit;
            wait_led_n <= phase_lit ? LED_OFF : LED_ON;
          end else begin
            blink_cnt <= blink_cnt + 32'd1;
          end
        end
        SERVING: begin
          if (walk_d && !walk_active) begin
            state    <= LOCKOUT;
            cool_cnt <= '0;
          end
        end
        LOCKOUT: begin
          if (cool_cnt == COOL_LAST) begin
            state <= IDLE;
          end else begin
            cool_cnt <= cool_cnt + 32'd1;
          end
        end
      endcase
    end
  end

  assign req = (state == PENDING);

endmodule
